// File: rtl/softplus_pkg.sv
// ---------------------------------------------------------------------------
// softplus_pkg
//
// Shared definitions for the softplus vector sequencer and the team that owns
// the softplus datapath:
//   - SP_DATA_W   : fixed-point activation word width
//   - SP_PIPE_LAT : default datapath latency, input to output, in cycles
//   - state_t     : sequencer FSM state encoding (IDLE, RUN, DRAIN, DONE)
//   - fifo_cnt_w  : width of an occupancy counter for a given FIFO depth
// ---------------------------------------------------------------------------
package softplus_pkg;

  localparam int SP_DATA_W   = 16;
  localparam int SP_PIPE_LAT = 2;

  // Plain vector encoding so the state can be probed and compared
  // directly by tools and logic that only know about bit vectors.
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // An occupancy counter must represent 0..depth inclusive.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : softplus_pkg

// File: rtl/sync_fifo_tagged.sv
// ---------------------------------------------------------------------------
// sync_fifo_tagged
//
// Small synchronous first-word-fall-through FIFO that holds a result word
// concatenated with its element index tag.
//
// Ports:
//   clk        : clock, all state on the rising edge
//   reset      : synchronous, active-high; empties the FIFO
//   push       : write push_data this cycle
//   push_data  : entry to write ({data, idx} in the sequencer)
//   pop        : remove the head entry this cycle
//   pop_data   : head entry, valid while empty == 0
//   full       : count == DEPTH
//   empty      : count == 0
//   count      : current occupancy, 0..DEPTH
//
// A simultaneous push and pop is accepted even when full: the head leaves
// and the new entry takes its slot, so occupancy is unchanged.
// ---------------------------------------------------------------------------
module sync_fifo_tagged
  import softplus_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        pop_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = fifo_cnt_w(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic do_push;
  logic do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every signal written here gets a value on every path before any
    // condition is tested; otherwise synthesis infers a latch to hold it.
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    // DEPTH is a power of two, so pointer wrap is plain overflow.
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop, whatever the order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset. Emptiness is tracked by the
  // counter alone, and leaving the RAM unreset lets it map to LUT-RAM or
  // a register file without a reset fan-out to every bit.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule : sync_fifo_tagged

// File: rtl/softplus_vector_sequencer.sv
// ---------------------------------------------------------------------------
// softplus_vector_sequencer
//
// Streams a vector of fixed-point pre-activations out of a synchronous RAM,
// through one shared softplus datapath (fixed latency, cannot stall), and
// into a small output FIFO that drains on a valid/ready stream. Each result
// is tagged with its element index.
//
// Ports:
//   clk, reset    : clock; synchronous active-high reset
//   start         : one-cycle launch pulse, honoured only while idle
//   base_addr     : RAM address of element 0 (sampled on start)
//   len           : element count 0..2^ADDR_W (sampled on start)
//   busy          : high from the accepted start until done
//   done          : one-cycle pulse once the last result has been accepted
//   mem_rd_en     : RAM read strobe
//   mem_rd_addr   : RAM read address, base + element index modulo 2^ADDR_W
//   mem_rd_data   : RAM read data, RD_LAT cycles after mem_rd_en
//   sp_data_in    : operand to the softplus datapath (0 on bubbles)
//   sp_data_out   : datapath result, PIPE_LAT cycles after sp_data_in
//   res_valid     : output FIFO head valid
//   res_ready     : downstream accept
//   res_data      : softplus result at the FIFO head (0 when empty)
//   res_idx       : element index of res_data (0 when empty)
//
// Flow control: an element is only read when the FIFO is guaranteed a free
// slot for it on arrival, i.e. FIFO occupancy plus elements still in the
// read/datapath pipeline stays below FIFO_DEPTH. Because the datapath
// cannot stall, this credit rule is what prevents FIFO overflow.
// ---------------------------------------------------------------------------
module softplus_vector_sequencer
  import softplus_pkg::*;
#(
  parameter int DATA_W     = SP_DATA_W,
  parameter int ADDR_W     = 8,
  parameter int RD_LAT     = 1,
  parameter int PIPE_LAT   = SP_PIPE_LAT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] sp_data_in,
  input  logic [DATA_W-1:0] sp_data_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [ADDR_W-1:0] res_idx
);

  // Tracking pipe covers the RAM read plus the datapath.
  localparam int TRK_LEN = RD_LAT + PIPE_LAT;
  localparam int CNT_W   = fifo_cnt_w(FIFO_DEPTH);
  localparam int INF_W   = $clog2(TRK_LEN + 1);
  localparam int OCC_W   = CNT_W + INF_W;
  localparam int ENT_W   = DATA_W + ADDR_W;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t                          state_q, state_d;
  logic [ADDR_W-1:0]               base_q, base_d;
  logic [ADDR_W:0]                 len_q, len_d;
  logic [ADDR_W:0]                 issue_cnt_q, issue_cnt_d;
  logic [TRK_LEN-1:0]              trk_valid_q, trk_valid_d;
  logic [TRK_LEN-1:0][ADDR_W-1:0]  trk_idx_q, trk_idx_d;

  // -------------------------------------------------------------------------
  // Combinational helpers
  // -------------------------------------------------------------------------
  logic              issue;
  logic              credit_ok;
  logic [INF_W-1:0]  inflight_cnt;
  logic [OCC_W-1:0]  occupancy;
  logic [ADDR_W-1:0] issue_idx;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [ENT_W-1:0]  fifo_wdata;
  logic [ENT_W-1:0]  fifo_rdata;

  // Elements already committed to a FIFO slot: those queued in the FIFO
  // plus those still travelling through the RAM read and the datapath.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < TRK_LEN; i++) begin
      inflight_cnt = inflight_cnt + INF_W'(trk_valid_q[i]);
    end
    occupancy = OCC_W'(fifo_count) + OCC_W'(inflight_cnt);
    credit_ok = (occupancy < OCC_W'(FIFO_DEPTH));
  end

  // Element index is the low ADDR_W bits of the issue counter; a full
  // 2^ADDR_W vector therefore tags 0..2^ADDR_W-1.
  assign issue_idx = issue_cnt_q[ADDR_W-1:0];

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    issue       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d      = base_addr;
          len_d       = len;
          issue_cnt_d = '0;
          state_d     = (len == '0) ? ST_DONE : ST_RUN;
        end
      end

      ST_RUN: begin
        if (issue_cnt_q == len_q) begin
          state_d = ST_DRAIN;
        end else if (credit_ok) begin
          issue       = 1'b1;
          issue_cnt_d = issue_cnt_q + (ADDR_W + 1)'(1);
        end
      end

      // done must follow the final downstream accept, so wait for both the
      // pipeline and the FIFO to be empty.
      ST_DRAIN: begin
        if ((inflight_cnt == '0) && fifo_empty) state_d = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Tracking shift register: one valid/index tag per element in flight.
  // It advances every cycle; a bubble enters whenever nothing is issued.
  // -------------------------------------------------------------------------
  always_comb begin
    trk_valid_d = {trk_valid_q[TRK_LEN-2:0], issue};
    trk_idx_d   = {trk_idx_q[TRK_LEN-2:0], (issue ? issue_idx : {ADDR_W{1'b0}})};
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      trk_valid_q <= '0;
      trk_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      trk_valid_q <= trk_valid_d;
      trk_idx_q   <= trk_idx_d;
    end
  end

  // -------------------------------------------------------------------------
  // RAM and datapath interface
  // -------------------------------------------------------------------------
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign mem_rd_en   = issue;
  // Address wraps modulo 2^ADDR_W by construction of the adder width.
  assign mem_rd_addr = issue ? (base_q + issue_idx) : '0;

  // Only forward RAM data in the cycle its tag says it is live, so the
  // datapath sees zeros on bubbles rather than stale read data.
  assign sp_data_in  = trk_valid_q[RD_LAT-1] ? mem_rd_data : '0;

  // Results leave the datapath in the same cycle their tag reaches the end
  // of the tracking pipe. Tags cleared by reset make late datapath outputs
  // from an aborted vector harmless.
  assign fifo_push   = trk_valid_q[TRK_LEN-1];
  assign fifo_wdata  = {sp_data_out, trk_idx_q[TRK_LEN-1]};

  // -------------------------------------------------------------------------
  // Output FIFO
  // -------------------------------------------------------------------------
  assign res_valid = !fifo_empty;
  assign fifo_pop  = res_valid && res_ready;

  sync_fifo_tagged #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Hold outputs at zero while empty so the stream never exposes stale
  // storage contents.
  assign res_data = res_valid ? fifo_rdata[ENT_W-1:ADDR_W] : '0;
  assign res_idx  = res_valid ? fifo_rdata[ADDR_W-1:0]     : '0;

  // The credit rule means a push can only meet a full FIFO if a pop frees
  // the slot in the same cycle.
  push_into_full_a : assert property (
    @(posedge clk) disable iff (reset) (fifo_push && fifo_full) |-> fifo_pop
  );

endmodule : softplus_vector_sequencer

// File: tb/tb_softplus_vector_sequencer.sv
// ---------------------------------------------------------------------------
// tb_softplus_vector_sequencer
//
// Directed bench for softplus_vector_sequencer. A RAM model holds
// mem[a] = a*2 and the datapath stub returns in+1 two cycles later, so
// element i of a vector at base b must come back as ((b+i) mod 256)*2 + 1
// tagged with index i. A monitor compares every read address and every
// accepted result against that rule, checks data stability under stall and
// the credit bound, and records timing for the directed checks below.
// ---------------------------------------------------------------------------
module tb_softplus_vector_sequencer;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int BUDGET     = 600;

  logic              clk;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] sp_data_in;
  logic [DATA_W-1:0] sp_data_out;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [ADDR_W-1:0] res_idx;

  softplus_vector_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .len         (len),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .sp_data_in  (sp_data_in),
    .sp_data_out (sp_data_out),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_idx     (res_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM with one cycle read latency.
  logic [DATA_W-1:0] ram [256];
  initial begin
    for (int a = 0; a < 256; a++) ram[a] = DATA_W'(a * 2);
  end
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
  end

  // Datapath stub: out = in + 1, two cycles later.
  logic [DATA_W-1:0] sp_p1, sp_p2;
  always @(posedge clk) begin
    sp_p1 <= sp_data_in + 16'd1;
    sp_p2 <= sp_p1;
  end
  assign sp_data_out = sp_p2;

  // -------------------------------------------------------------------------
  // Scoreboard state
  // -------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  int cyc = 0;
  logic [7:0] exp_base;
  int exp_len, issue_seen, rx_cnt, done_cnt, busy_cycles;
  int first_rd, first_val, start_cyc, done_cyc, occ;
  logic [15:0] rx_data_log [32];
  logic [7:0]  rx_idx_log  [32];
  logic [7:0]  rd_addr_log [32];
  logic        prev_stall;
  logic [15:0] prev_data;
  logic [7:0]  prev_idx;

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act_v, exp_v, cyc);
    end
  endtask

  function automatic logic [15:0] exp_data(input int i);
    logic [7:0] a;
    a = exp_base + 8'(i);
    return 16'({a, 1'b0}) + 16'd1;
  endfunction

  task automatic begin_vec(input logic [7:0] b, input int l);
    exp_base    = b;
    exp_len     = l;
    issue_seen  = 0;
    rx_cnt      = 0;
    done_cnt    = 0;
    busy_cycles = 0;
    first_rd    = -1;
    first_val   = -1;
    start_cyc   = -1;
    done_cyc    = -1;
  endtask

  // -------------------------------------------------------------------------
  // Monitor: samples on the falling edge, mid-cycle.
  // -------------------------------------------------------------------------
  initial begin
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        occ = issue_seen - rx_cnt;
        if (start && !busy) start_cyc = cyc;
        if (busy) busy_cycles++;

        if (mem_rd_en) begin
          if (issue_seen < exp_len) begin
            check("rd_addr", 32'(mem_rd_addr), 32'(8'(exp_base + 8'(issue_seen))));
            check("credit_bound", 32'(occ < FIFO_DEPTH), 32'd1);
            if (issue_seen < 32) rd_addr_log[issue_seen] = mem_rd_addr;
            if (first_rd < 0) first_rd = cyc;
            issue_seen++;
          end else begin
            checks++;
            failures++;
            $display("FAIL extra_read: addr 0x%0h after %0d of %0d reads (cycle %0d)",
                     mem_rd_addr, issue_seen, exp_len, cyc);
          end
        end

        if (prev_stall) begin
          check("stall_valid", 32'(res_valid), 32'd1);
          check("stall_data", 32'(res_data), 32'(prev_data));
          check("stall_idx", 32'(res_idx), 32'(prev_idx));
        end

        if (res_valid && first_val < 0) first_val = cyc;

        if (res_valid && res_ready) begin
          if (rx_cnt < exp_len) begin
            check("res_data", 32'(res_data), 32'(exp_data(rx_cnt)));
            check("res_idx", 32'(res_idx), 32'(8'(rx_cnt)));
            if (rx_cnt < 32) begin
              rx_data_log[rx_cnt] = res_data;
              rx_idx_log[rx_cnt]  = res_idx;
            end
            rx_cnt++;
          end else begin
            checks++;
            failures++;
            $display("FAIL extra_result: data 0x%0h idx %0d after %0d of %0d (cycle %0d)",
                     res_data, res_idx, rx_cnt, exp_len, cyc);
          end
        end

        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          check("done_after_all", rx_cnt, exp_len);
          check("done_busy", 32'(busy), 32'd1);
        end

        prev_stall = res_valid && !res_ready;
        prev_data  = res_data;
        prev_idx   = res_idx;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},        32'(busy),        32'd0);
    check({tag, "_done"},        32'(done),        32'd0);
    check({tag, "_mem_rd_en"},   32'(mem_rd_en),   32'd0);
    check({tag, "_mem_rd_addr"}, 32'(mem_rd_addr), 32'd0);
    check({tag, "_sp_data_in"},  32'(sp_data_in),  32'd0);
    check({tag, "_res_valid"},   32'(res_valid),   32'd0);
    check({tag, "_res_data"},    32'(res_data),    32'd0);
    check({tag, "_res_idx"},     32'(res_idx),     32'd0);
  endtask

  // mode 0: res_ready held high; mode 1: toggles every cycle;
  // mode 2: held low for 'hold' cycles after start, then high.
  task automatic run_vec(input logic [7:0] b, input logic [8:0] l, input int mode, input int hold);
    int n;
    begin_vec(b, int'(l));
    @(posedge clk); #1;
    base_addr = b;
    len       = l;
    start     = 1'b1;
    res_ready = (mode == 0);
    n = 0;
    while (done_cnt == 0 && n < BUDGET) begin
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      case (mode)
        1:       res_ready = !res_ready;
        2:       res_ready = (n >= hold);
        default: res_ready = 1'b1;
      endcase
      if (mode == 2 && n == hold) check("stall_reads", issue_seen, FIFO_DEPTH);
    end
    if (done_cnt == 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: no done within %0d cycles (base 0x%0h len %0d)", BUDGET, b, l);
    end
    @(negedge clk);
    check("busy_after_done", 32'(busy), 32'd0);
    check("done_single", done_cnt, 1);
    check("rx_count", rx_cnt, int'(l));
  endtask

  // -------------------------------------------------------------------------
  // Directed tests
  // -------------------------------------------------------------------------
  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    res_ready = 1'b0;
    begin_vec(8'h00, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset");

    // 1: basic vector, full throughput downstream.
    run_vec(8'h10, 9'd5, 0, 0);
    check("t1_data0", 32'(rx_data_log[0]), 32'h21);
    check("t1_data4", 32'(rx_data_log[4]), 32'h29);
    check("t1_idx4", 32'(rx_idx_log[4]), 32'd4);
    check("t1_start_to_rd", first_rd - start_cyc, 1);
    check("t1_rd_to_valid", first_val - first_rd, 4);

    // 2: empty vector.
    run_vec(8'h33, 9'd0, 0, 0);
    check("t2_reads", issue_seen, 0);
    check("t2_busy_cycles", busy_cycles, 1);
    check("t2_done_latency", done_cyc - start_cyc, 1);

    // 3: downstream stalled for 20 cycles, credit limits reads to 4.
    run_vec(8'h00, 9'd16, 2, 20);
    check("t3_data15", 32'(rx_data_log[15]), 32'h1F);
    check("t3_idx15", 32'(rx_idx_log[15]), 32'd15);

    // 4: address wrap.
    run_vec(8'hFE, 9'd4, 0, 0);
    check("t4_addr0", 32'(rd_addr_log[0]), 32'hFE);
    check("t4_addr1", 32'(rd_addr_log[1]), 32'hFF);
    check("t4_addr2", 32'(rd_addr_log[2]), 32'h00);
    check("t4_addr3", 32'(rd_addr_log[3]), 32'h01);
    check("t4_data0", 32'(rx_data_log[0]), 32'h1FD);
    check("t4_data2", 32'(rx_data_log[2]), 32'h01);

    // 5: res_ready toggling every cycle.
    run_vec(8'h20, 9'd10, 1, 0);
    check("t5_idx9", 32'(rx_idx_log[9]), 32'd9);
    check("t5_data9", 32'(rx_data_log[9]), 32'h53);

    // 6: reset three cycles into a run, then a short clean run.
    begin_vec(8'h40, 8);
    @(posedge clk); #1;
    base_addr = 8'h40;
    len       = 9'd8;
    start     = 1'b1;
    res_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    reset = 1'b1;
    begin_vec(8'h00, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_outputs_zero("midreset");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_res_valid", 32'(res_valid), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end
    check("midreset_no_done", done_cnt, 0);
    run_vec(8'h30, 9'd2, 0, 0);
    check("t6_idx0", 32'(rx_idx_log[0]), 32'd0);
    check("t6_idx1", 32'(rx_idx_log[1]), 32'd1);
    check("t6_data1", 32'(rx_data_log[1]), 32'h63);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule : tb_softplus_vector_sequencer
